// File: rtl/fetch_buffer_pkg.sv
// Shared types for the instruction fetch buffer: FSM states, port groupings and helpers.
package fetch_buffer_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DROP = 1'b1
  } fetch_state_type;

  // Value shown on out_instr while the queue is empty.
  localparam logic [31:0] NOP = 32'h0;

  typedef struct packed {
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
  } fetch_in_type;

  typedef struct packed {
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
  } fetch_out_type;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer_fifo.sv
// Small {pc, instr} queue with wrap-bit pointers; flush empties it and overrides push/pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [63:0]              wdata,
  output logic [63:0]              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] head_q, head_d;
  logic [AW:0] tail_q, tail_d;
  logic [63:0] mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  always_comb begin
    count   = tail_q - head_q;
    empty   = (head_q == tail_q);
    full    = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    do_push = push & ~full & ~flush;
    do_pop  = pop & ~empty & ~flush;
    rdata   = mem_q[head_q[AW-1:0]];
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      head_d = tail_q;
    end else begin
      if (do_push) tail_d = tail_q + (AW+1)'(1);
      if (do_pop)  head_d = head_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[tail_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch/prefetch buffer: issues word fetches, queues responses, feeds decode,
// and discards in-flight responses after a redirect.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_valid,
  output logic [31:0]     imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  output logic [31:0]     out_instr,
  output logic [31:0]     out_pc,
  input  logic            out_ready,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output fetch_state_type dbg_state
);

  // Both sides use valid/ready: a transfer happens in any cycle where valid and ready are
  // both high; once imem_valid is raised it stays high with imem_addr stable until imem_ready.

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_in_type    fin;
  fetch_out_type   fout;
  fetch_state_type state_q, state_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [31:0]     tgt_pc_q, tgt_pc_d;
  logic            pending_q, pending_d;
  logic [31:0]     redir_tgt;
  logic            fifo_push, fifo_pop, fifo_flush;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [63:0]     fifo_rdata;

  assign fin = '{imem_ready:     imem_ready,
                 imem_rdata:     imem_rdata,
                 out_ready:      out_ready,
                 redirect_valid: redirect_valid,
                 redirect_pc:    redirect_pc};

  always_comb begin
    redir_tgt       = word_align(fin.redirect_pc);
    fout.imem_addr  = req_pc_q;
    fout.imem_valid = ~reset & ((state_q == DROP) | ~fifo_full | pending_q);
    fout.out_valid  = (fifo_count != '0);
    fout.out_instr  = fifo_empty ? NOP : fifo_rdata[31:0];
    fout.out_pc     = fifo_empty ? 32'h0 : fifo_rdata[63:32];

    state_d    = state_q;
    req_pc_d   = req_pc_q;
    tgt_pc_d   = tgt_pc_q;
    pending_d  = fout.imem_valid & ~fin.imem_ready;
    fifo_flush = fin.redirect_valid;
    fifo_pop   = fout.out_valid & fin.out_ready;
    fifo_push  = 1'b0;

    if (fin.redirect_valid) begin
      // A presented-but-unanswered request must still complete, so its data gets dropped later.
      if (!fout.imem_valid || fin.imem_ready) begin
        req_pc_d = redir_tgt;
        state_d  = RUN;
      end else begin
        tgt_pc_d = redir_tgt;
        state_d  = DROP;
      end
    end else if (state_q == DROP) begin
      if (fin.imem_ready) begin
        req_pc_d = tgt_pc_q;
        state_d  = RUN;
      end
    end else if (fout.imem_valid && fin.imem_ready) begin
      fifo_push = 1'b1;
      req_pc_d  = req_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      req_pc_q  <= word_align(RESET_PC);
      tgt_pc_q  <= 32'h0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      tgt_pc_q  <= tgt_pc_d;
      pending_q <= pending_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata ({req_pc_q, fin.imem_rdata}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign imem_valid = fout.imem_valid;
  assign imem_addr  = fout.imem_addr;
  assign out_valid  = fout.out_valid;
  assign out_instr  = fout.out_instr;
  assign out_pc     = fout.out_pc;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a queue-based reference model and a latency-configurable memory.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  // ---------------- clock / reset ----------------
  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            imem_valid;
  logic [31:0]     imem_addr;
  logic            imem_ready = 1'b0;
  logic [31:0]     imem_rdata = 32'h0;
  logic            out_valid;
  logic [31:0]     out_instr;
  logic [31:0]     out_pc;
  logic            out_ready = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [31:0]     redirect_pc = 32'h0;
  fetch_state_type dbg_state;

  always #5 clock = ~clock;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_valid     (imem_valid),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          chk_en = 1'b0;

  logic [63:0] exp_q[$];
  logic [31:0] m_req = RESET_PC;
  logic [31:0] m_tgt = 32'h0;
  bit          m_drop = 1'b0;
  bit          m_out  = 1'b0;

  int          lat = 0;
  int          wcnt = 0;
  int          wcnt_next = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // A fetch is being presented: always while dropping, else if there is room or one is in flight.
  function automatic bit m_valid();
    return !reset && (m_drop || exp_q.size() < DEPTH || m_out);
  endfunction

  // Applies what the last rising edge did, from the inputs that were applied to it.
  task automatic model_step();
    bit mv;
    if (reset) begin
      exp_q.delete();
      m_req  = RESET_PC;
      m_tgt  = 32'h0;
      m_drop = 1'b0;
      m_out  = 1'b0;
    end else begin
      mv = m_valid();
      if (redirect_valid) begin
        exp_q.delete();
        if (!mv || imem_ready) begin
          m_req  = {redirect_pc[31:2], 2'b00};
          m_drop = 1'b0;
          m_out  = 1'b0;
        end else begin
          m_tgt  = {redirect_pc[31:2], 2'b00};
          m_drop = 1'b1;
          m_out  = 1'b1;
        end
      end else if (m_drop) begin
        if (imem_ready) begin
          m_req  = m_tgt;
          m_drop = 1'b0;
          m_out  = 1'b0;
        end
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (mv && imem_ready) begin
          exp_q.push_back({m_req, imem_rdata});
          m_req = m_req + 32'd4;
        end
        m_out = mv && !imem_ready;
      end
    end
  endtask

  // ---------------- compare process ----------------
  logic        cmp_ev;
  logic [63:0] cmp_head;

  always @(negedge clock) begin
    #2;
    if (chk_en) begin
      cmp_ev   = m_valid();
      cmp_head = (exp_q.size() != 0) ? exp_q[0] : 64'h0;
      chk("imem_valid", imem_valid, cmp_ev);
      if (cmp_ev) chk("imem_addr", imem_addr, m_req);
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("out_pc", out_pc, cmp_head[63:32]);
      chk("out_instr", out_instr, cmp_head[31:0]);
      chk("state", dbg_state, m_drop);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rst, input bit ordy);
    @(negedge clock);
    model_step();
    reset          = rst;
    out_ready      = ordy;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    wcnt           = wcnt_next;
    #1;
    imem_ready = imem_valid && (wcnt >= lat);
    imem_rdata = imem_ready ? word_of(imem_addr) : 32'hDEAD_BEEF;
    wcnt_next  = (reset || !imem_valid || imem_ready) ? 0 : wcnt + 1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
  endtask

  task automatic do_reset();
    lat = 0;
    drive(1'b1, 1'b0);
    chk_en = 1'b1;
    drive(1'b1, 1'b0);
  endtask

  task automatic wait_out(input string name, input logic [31:0] exp_pc);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      drive(1'b0, 1'b1);
      n++;
    end
    chk({name, "_seen"}, out_valid, 1'b1);
    chk({name, "_pc"}, out_pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // Zero-wait streaming, decode always ready.
    do_reset();
    drive(1'b0, 1'b1);
    chk("s1_valid0", imem_valid, 1'b1);
    chk("s1_addr0", imem_addr, 32'h0);
    chk("s1_ov0", out_valid, 1'b0);
    drive(1'b0, 1'b1);
    chk("s1_addr1", imem_addr, 32'h4);
    chk("s1_ov1", out_valid, 1'b1);
    chk("s1_pc1", out_pc, 32'h0);
    chk("s1_instr1", out_instr, 32'hC0DE_0000);
    drive(1'b0, 1'b1);
    chk("s1_addr2", imem_addr, 32'h8);
    chk("s1_pc2", out_pc, 32'h4);
    chk("s1_instr2", out_instr, 32'hC0DE_0004);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);

    // Fill with decode stalled, then release.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    chk("s2_full_valid", imem_valid, 1'b0);
    chk("s2_full_addr", imem_addr, 32'h10);
    chk("s2_full_pc", out_pc, 32'h0);
    drive(1'b0, 1'b1);
    chk("s2_pop_valid", imem_valid, 1'b0);
    drive(1'b0, 1'b1);
    chk("s2_rise_valid", imem_valid, 1'b1);
    chk("s2_rise_pc", out_pc, 32'h4);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1);

    // Redirect during the second wait cycle of a slow fetch.
    do_reset();
    lat = 3;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    redirect(32'h100);
    drive(1'b0, 1'b1);
    chk("s3_hold_addr", imem_addr, 32'h0);
    chk("s3_drop", dbg_state, DROP);
    drive(1'b0, 1'b1);
    chk("s3_ready", imem_ready, 1'b1);
    chk("s3_hold_addr2", imem_addr, 32'h0);
    drive(1'b0, 1'b1);
    chk("s3_new_addr", imem_addr, 32'h100);
    chk("s3_new_valid", imem_valid, 1'b1);
    chk("s3_ov", out_valid, 1'b0);
    wait_out("s3", 32'h100);

    // Redirect to an unaligned target together with a response and a pop.
    do_reset();
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    redirect(32'h203);
    drive(1'b0, 1'b1);
    chk("s4_ov", out_valid, 1'b0);
    chk("s4_addr", imem_addr, 32'h200);
    wait_out("s4", 32'h200);

    // Two redirects while dropping; the last one wins.
    do_reset();
    lat = 4;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    redirect(32'h40);
    drive(1'b0, 1'b1);
    redirect(32'h80);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    lat = 0;
    drive(1'b0, 1'b1);
    chk("s5_addr", imem_addr, 32'h80);
    wait_out("s5", 32'h80);

    // Reset with three entries queued and a request in flight.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    lat = 5;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    chk("s6_pend_valid", imem_valid, 1'b1);
    chk("s6_pend_addr", imem_addr, 32'hC);
    drive(1'b1, 1'b0);
    chk("s6_rst_valid", imem_valid, 1'b0);
    drive(1'b1, 1'b0);
    chk("s6_after_ov", out_valid, 1'b0);
    chk("s6_after_valid", imem_valid, 1'b0);
    lat = 0;
    drive(1'b0, 1'b1);
    chk("s6_restart_addr", imem_addr, RESET_PC);
    wait_out("s6", RESET_PC);

    // Fetch address wraps past the top of memory.
    do_reset();
    drive(1'b0, 1'b1);
    redirect(32'hFFFF_FFFC);
    drive(1'b0, 1'b1);
    chk("s7_addr", imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 1'b1);
    chk("s7_pc_top", out_pc, 32'hFFFF_FFFC);
    chk("s7_addr_wrap", imem_addr, 32'h0);
    drive(1'b0, 1'b1);
    chk("s7_pc_wrap", out_pc, 32'h0);
    chk("s7_instr_wrap", out_instr, 32'hC0DE_0000);

    // Mixed traffic: one-wait memory, intermittent decode stalls, two redirects.
    do_reset();
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, (i % 3) != 0);
      if (i == 17) redirect(32'h0000_0321);
      if (i == 29) redirect(32'h0000_0500);
    end
    drive(1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
